// File: rtl/fc_act_serializer.sv
// Serializes an FC layer's accumulator vector into one saturated (optionally ReLU'd)
// activation per valid/ready beat; vectors arriving while busy are dropped and flagged.
module fc_act_serializer #(
  parameter int NUM_NEURONS = 8,
  parameter int ACC_WIDTH   = 32,
  parameter int DATA_WIDTH  = 8,
  parameter int RELU_EN     = 1,
  localparam int IW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   vec_valid,
  input  logic [NUM_NEURONS-1:0][ACC_WIDTH-1:0]  vec_in,
  output logic                                   vec_ready,
  output logic                                   vec_drop,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic signed [DATA_WIDTH-1:0]           out_data,
  output logic [IW-1:0]                          out_index,
  output logic                                   out_last,
  output logic                                   out_sat
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NEURONS - 1);
  localparam logic signed [ACC_WIDTH-1:0] MAX_V =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MIN_V =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                vec_drop_q;
  logic                at_last;
  logic                cap;
  logic [DATA_WIDTH:0] act_buf_p1 [NUM_NEURONS];

  // Packed result is {sat, data}: saturation flag travels with the clamped value.
  function automatic logic [DATA_WIDTH:0] saturate(input logic signed [ACC_WIDTH-1:0] x);
    logic signed [ACC_WIDTH-1:0] y;
    y = ((RELU_EN != 0) && (x < 0)) ? '0 : x;
    if (y > MAX_V)      return {1'b1, MAX_V[DATA_WIDTH-1:0]};
    else if (y < MIN_V) return {1'b1, MIN_V[DATA_WIDTH-1:0]};
    else                return {1'b0, y[DATA_WIDTH-1:0]};
  endfunction

  assign at_last   = (idx_q == LAST_IDX);
  assign out_valid = (state_q == SEND);
  assign vec_ready = (state_q == IDLE) || (out_valid && at_last && out_ready);
  assign cap       = vec_valid && vec_ready;

  assign out_index = idx_q;
  assign out_last  = out_valid && at_last;
  assign out_data  = out_valid ? $signed(act_buf_p1[idx_q][DATA_WIDTH-1:0]) : '0;
  assign out_sat   = out_valid ? act_buf_p1[idx_q][DATA_WIDTH] : 1'b0;
  assign vec_drop  = vec_drop_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (cap) begin
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (at_last) begin
            state_d = cap ? SEND : IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      vec_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      vec_drop_q <= vec_valid && !vec_ready;
    end
  end

  // Stage p1: whole vector converted and captured in one cycle; data path carries no reset.
  always_ff @(posedge clk) begin
    if (cap) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        act_buf_p1[i] <= saturate($signed(vec_in[i]));
      end
    end
  end

endmodule

// File: tb/tb_fc_act_serializer.sv
// Bench for fc_act_serializer: a ReLU and a pass-sign instance share stimulus; beats are
// scored against an integer reference model through per-instance expectation queues.
module tb_fc_act_serializer;

  typedef struct packed {
    logic signed [7:0] data;
    logic [1:0]        idx;
    logic              sat;
    logic              last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              vec_valid = 1'b0;
  logic [3:0][31:0]  vec_in = '0;
  logic              out_ready = 1'b1;

  logic              r_vec_ready, r_vec_drop, r_valid, r_last, r_sat;
  logic signed [7:0] r_data;
  logic [1:0]        r_index;
  logic              n_vec_ready, n_vec_drop, n_valid, n_last, n_sat;
  logic signed [7:0] n_data;
  logic [1:0]        n_index;

  beat_t q_r[$];
  beat_t q_n[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fc_act_serializer #(.NUM_NEURONS(4), .ACC_WIDTH(32), .DATA_WIDTH(8), .RELU_EN(1)) dut_relu (
    .clk(clk), .rst_n(rst_n), .vec_valid(vec_valid), .vec_in(vec_in),
    .vec_ready(r_vec_ready), .vec_drop(r_vec_drop), .out_valid(r_valid),
    .out_ready(out_ready), .out_data(r_data), .out_index(r_index),
    .out_last(r_last), .out_sat(r_sat));

  fc_act_serializer #(.NUM_NEURONS(4), .ACC_WIDTH(32), .DATA_WIDTH(8), .RELU_EN(0)) dut_sign (
    .clk(clk), .rst_n(rst_n), .vec_valid(vec_valid), .vec_in(vec_in),
    .vec_ready(n_vec_ready), .vec_drop(n_vec_drop), .out_valid(n_valid),
    .out_ready(out_ready), .out_data(n_data), .out_index(n_index),
    .out_last(n_last), .out_sat(n_sat));

  function automatic beat_t model(input int x, input bit relu, input int i);
    beat_t b;
    int y;
    y = (relu && x < 0) ? 0 : x;
    b.sat = 1'b0;
    if (y > 127) begin
      y = 127;
      b.sat = 1'b1;
    end else if (y < -128) begin
      y = -128;
      b.sat = 1'b1;
    end
    b.data = 8'(y);
    b.idx  = 2'(i);
    b.last = (i == 3);
    return b;
  endfunction

  // Scoreboard: every handshaken beat must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (r_valid && out_ready) begin
        checks++;
        if (q_r.size() == 0) begin
          errors++;
          $display("FAIL relu_beat unexpected beat idx=%0d data=%0d", r_index, r_data);
        end else begin
          beat_t e;
          e = q_r.pop_front();
          if ({r_data, r_index, r_sat, r_last} !== e) begin
            errors++;
            $display("FAIL relu_beat got data=%0d idx=%0d sat=%b last=%b want data=%0d idx=%0d sat=%b last=%b",
                     r_data, r_index, r_sat, r_last, e.data, e.idx, e.sat, e.last);
          end
        end
      end
      if (n_valid && out_ready) begin
        checks++;
        if (q_n.size() == 0) begin
          errors++;
          $display("FAIL sign_beat unexpected beat idx=%0d data=%0d", n_index, n_data);
        end else begin
          beat_t e;
          e = q_n.pop_front();
          if ({n_data, n_index, n_sat, n_last} !== e) begin
            errors++;
            $display("FAIL sign_beat got data=%0d idx=%0d sat=%b last=%b want data=%0d idx=%0d sat=%b last=%b",
                     n_data, n_index, n_sat, n_last, e.data, e.idx, e.sat, e.last);
          end
        end
      end
    end
  end

  task automatic push_expect(input int e0, input int e1, input int e2, input int e3);
    int v[4];
    v = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      q_r.push_back(model(v[i], 1'b1, i));
      q_n.push_back(model(v[i], 1'b0, i));
    end
  endtask

  task automatic set_vec(input int e0, input int e1, input int e2, input int e3);
    vec_in[0] = 32'(e0);
    vec_in[1] = 32'(e1);
    vec_in[2] = 32'(e2);
    vec_in[3] = 32'(e3);
  endtask

  // Returns 1ns after the capture edge, with beat 0 on the outputs.
  task automatic drive_vec(input int e0, input int e1, input int e2, input int e3);
    @(posedge clk); #1;
    set_vec(e0, e1, e2, e3);
    vec_valid = 1'b1;
    push_expect(e0, e1, e2, e3);
    @(posedge clk); #1;
    vec_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q_r.size() != 0 || q_n.size() != 0) && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (q_r.size() != 0 || q_n.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending relu=%0d sign=%0d want 0", q_r.size(), q_n.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({r_valid, r_data, r_index, r_last, r_sat, r_vec_drop} !== '0 ||
        {n_valid, n_data, n_index, n_last, n_sat, n_vec_drop} !== '0) begin
      errors++;
      $display("FAIL reset_outputs relu v=%b d=%0d i=%0d l=%b s=%b dr=%b sign v=%b d=%0d want all 0",
               r_valid, r_data, r_index, r_last, r_sat, r_vec_drop, n_valid, n_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (r_vec_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", r_vec_ready);
    end
  endtask

  task automatic test_relu_and_sign();
    out_ready = 1'b1;
    drive_vec(5, -3, 200, -200);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (r_valid !== 1'b1 || r_index !== 2'(k) || r_last !== 1'(k == 3) || n_valid !== 1'b1) begin
        errors++;
        $display("FAIL beat_timing k=%0d got v=%b idx=%0d last=%b want v=1 idx=%0d last=%b",
                 k, r_valid, r_index, r_last, k, (k == 3));
      end
    end
    @(negedge clk);
    checks++;
    if (r_valid !== 1'b0 || n_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_last got relu_v=%b sign_v=%b want 0", r_valid, n_valid);
    end
    wait_drain();
  endtask

  task automatic test_boundaries();
    drive_vec(127, 128, -128, -129);
    wait_drain();
  endtask

  task automatic test_backpressure();
    drive_vec(10, 20, 30, 40);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (r_valid !== 1'b1 || r_index !== 2'd1 || r_data !== 8'sd20 || r_sat !== 1'b0 ||
          n_data !== 8'sd20) begin
        errors++;
        $display("FAIL hold k=%0d got v=%b idx=%0d data=%0d sat=%b want v=1 idx=1 data=20 sat=0",
                 k, r_valid, r_index, r_data, r_sat);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_drop_and_back_to_back();
    drive_vec(1, 2, 3, 4);
    @(posedge clk); #1;
    set_vec(99, 99, 99, 99);
    vec_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (r_vec_ready !== 1'b0 || r_vec_drop !== 1'b0) begin
      errors++;
      $display("FAIL drop_before got ready=%b drop=%b want ready=0 drop=0", r_vec_ready, r_vec_drop);
    end
    @(posedge clk); #1;
    vec_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (r_vec_drop !== 1'b1 || n_vec_drop !== 1'b1) begin
      errors++;
      $display("FAIL drop_pulse got relu=%b sign=%b want 1", r_vec_drop, n_vec_drop);
    end
    @(negedge clk);
    checks++;
    if (r_vec_drop !== 1'b0 || r_index !== 2'd3) begin
      errors++;
      $display("FAIL drop_clear got drop=%b idx=%0d want drop=0 idx=3", r_vec_drop, r_index);
    end
    set_vec(-7, 300, -300, 64);
    vec_valid = 1'b1;
    push_expect(-7, 300, -300, 64);
    #1;
    checks++;
    if (r_vec_ready !== 1'b1) begin
      errors++;
      $display("FAIL last_beat_ready got %b want 1", r_vec_ready);
    end
    @(posedge clk); #1;
    vec_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (r_valid !== 1'b1 || r_index !== 2'd0) begin
      errors++;
      $display("FAIL back_to_back got v=%b idx=%0d want v=1 idx=0", r_valid, r_index);
    end
    wait_drain();
  endtask

  task automatic test_async_reset();
    drive_vec(11, 22, 33, 44);
    @(posedge clk);
    @(posedge clk); #2;
    checks++;
    if (r_index !== 2'd2) begin
      errors++;
      $display("FAIL pre_reset_idx got %0d want 2", r_index);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (r_valid !== 1'b0 || r_index !== 2'd0 || r_last !== 1'b0 || n_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got v=%b idx=%0d last=%b want 0", r_valid, r_index, r_last);
    end
    q_r.delete();
    q_n.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
    #1;
    checks++;
    if (r_vec_ready !== 1'b1 || n_vec_ready !== 1'b1 || r_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset got ready=%b v=%b want ready=1 v=0", r_vec_ready, r_valid);
    end
    drive_vec(-1, 127, 1000, -5);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_relu_and_sign();
    test_boundaries();
    test_backpressure();
    test_drop_and_back_to_back();
    test_async_reset();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
